// File: rtl/pong_pkg.sv
// pong_pkg: shared constants for the Pong match sequencer and ball datapath.
//   - FSM state encoding (also what the state_o debug port reports)
//   - ball centre coordinates loaded on recentre
//   - serve direction encoding (x-velocity sign bit)
//   - max2 helper for sizing the shared countdown
package pong_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SERVE = 3'd1;
  localparam state_t ST_RALLY = 3'd2;
  localparam state_t ST_POINT = 3'd3;
  localparam state_t ST_OVER  = 3'd4;

  localparam int CX = 320;
  localparam int CY = 240;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_countdown.sv
// tick_countdown: loadable down-counter that steps once per tick and parks at 0.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset (count -> 0)
//   i_load          load i_value this cycle; load beats a coincident tick
//   i_value         value to load
//   i_tick          decrement enable (ignored once the count is 0)
//   o_zero          count == 0
module tick_countdown #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_tick,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)                      r_cnt <= '0;
    else if (i_load)                  r_cnt <= i_value;
    else if (i_tick && r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer. Decides when the ball may move, when it is
// recentred, which way it is served and when a point is scored.
// Build option: AUTO_SERVE_EN -- when defined the ball is released as soon as
// the serve countdown expires; otherwise the player must also press serve_btn.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_tick           one pulse per ball-update period (drives the countdowns)
//   i_start          starts a match from IDLE or OVER
//   i_serve_btn      manual release from SERVE (unused with AUTO_SERVE_EN)
//   i_miss_left/right  ball passed left/right paddle (P2/P1 scores)
//   o_ball_hold      ball frozen (everywhere except RALLY)
//   o_ball_recenter  one-cycle pulse on entry to SERVE
//   o_serve_dir      0 = serve rightwards, 1 = leftwards
//   o_score_p1/p2    saturating binary scores
//   o_point_pulse    one-cycle pulse per score increment
//   o_game_over, o_winner  match finished / who won (0 = P1)
//   o_state          current FSM state for debug
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int SCORE_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_serve_btn,
  input  logic               i_miss_left,
  input  logic               i_miss_right,
  output logic               o_ball_hold,
  output logic               o_ball_recenter,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_score_p1,
  output logic [SCORE_W-1:0] o_score_p2,
  output logic               o_point_pulse,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  localparam int CNT_W = $clog2(max2(SERVE_TICKS, POINT_TICKS) + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic [SCORE_W-1:0] r_p1, r_p2;
  logic               r_dir, r_recenter, r_pulse;

  state_t             w_next;
  logic               w_load, w_clear, w_inc1, w_inc2, w_dir, w_zero, w_release;
  logic [CNT_W-1:0]   w_load_val;

`ifdef AUTO_SERVE_EN
  logic w_unused_btn;
  assign w_unused_btn = i_serve_btn;
  assign w_release    = 1'b1;
`else
  assign w_release    = i_serve_btn;
`endif

  // One countdown serves both SERVE and POINT; it is reloaded on every
  // transition into either, so a tick on the transition cycle is swallowed.
  tick_countdown #(.W(CNT_W)) u_cd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .i_tick  (i_tick),
    .o_zero  (w_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = CNT_W'(SERVE_TICKS);
    w_clear    = 1'b0;
    w_inc1     = 1'b0;
    w_inc2     = 1'b0;
    w_dir      = r_dir;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          w_next  = ST_SERVE;
          w_load  = 1'b1;
          w_clear = 1'b1;
        end
      end
      ST_SERVE: begin
        if (w_zero && w_release) w_next = ST_RALLY;
      end
      ST_RALLY: begin
        if (i_miss_left || i_miss_right) begin
          w_next     = ST_POINT;
          w_load     = 1'b1;
          w_load_val = CNT_W'(POINT_TICKS);
          // Simultaneous misses: nobody scores, serve side is kept.
          if (i_miss_left && !i_miss_right) begin
            w_inc2 = 1'b1;
            w_dir  = DIR_LEFT;
          end
          if (i_miss_right && !i_miss_left) begin
            w_inc1 = 1'b1;
            w_dir  = DIR_RIGHT;
          end
        end
      end
      ST_POINT: begin
        if (w_zero) begin
          if (r_p1 == WIN || r_p2 == WIN) begin
            w_next = ST_OVER;
          end else begin
            w_next = ST_SERVE;
            w_load = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_p1       <= '0;
      r_p2       <= '0;
      r_dir      <= DIR_RIGHT;
      r_recenter <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_recenter <= (w_next == ST_SERVE) && (r_state != ST_SERVE);
      r_pulse    <= (w_inc1 && r_p1 != WIN) || (w_inc2 && r_p2 != WIN);
      if (w_clear) begin
        r_p1  <= '0;
        r_p2  <= '0;
        r_dir <= DIR_RIGHT;
      end else begin
        r_dir <= w_dir;
        if (w_inc1 && r_p1 != WIN) r_p1 <= r_p1 + SCORE_W'(1);
        if (w_inc2 && r_p2 != WIN) r_p2 <= r_p2 + SCORE_W'(1);
      end
    end
  end

  assign o_ball_hold     = (r_state != ST_RALLY);
  assign o_ball_recenter = r_recenter;
  assign o_serve_dir     = r_dir;
  assign o_score_p1      = r_p1;
  assign o_score_p2      = r_p2;
  assign o_point_pulse   = r_pulse;
  assign o_game_over     = (r_state == ST_OVER);
  assign o_winner        = (r_state == ST_OVER) && (r_p2 == WIN);
  assign o_state         = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl with small parameters (WIN=4, SERVE=3, POINT=2).
// Works in both builds; serve-release expectations follow AUTO_SERVE_EN.
module tb_pong_match_ctrl;

  localparam int WIN = 4, STK = 3, PTK = 2, SW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2,
                         S_POINT = 3'd3, S_OVER = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1, tick = 1'b0, start = 1'b0, serve_btn = 1'b0;
  logic miss_left = 1'b0, miss_right = 1'b0;
  logic hold, recenter, dir, pulse, go, winner;
  logic [SW-1:0] p1, p2;
  logic [2:0] st;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(STK), .POINT_TICKS(PTK), .SCORE_W(SW)) dut (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start(start), .i_serve_btn(serve_btn),
    .i_miss_left(miss_left), .i_miss_right(miss_right), .o_ball_hold(hold),
    .o_ball_recenter(recenter), .o_serve_dir(dir), .o_score_p1(p1), .o_score_p2(p2),
    .o_point_pulse(pulse), .o_game_over(go), .o_winner(winner), .o_state(st)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int due;
    logic [SW-1:0] p1, p2;
    logic dir, pulse;
    logic [2:0] st;
  } exp_t;
  exp_t sbq[$];
  logic [SW-1:0] m_p1 = '0, m_p2 = '0;
  logic m_dir = 1'b0;

  // Scoreboard consumer: compares the registered result of each miss stimulus.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc_cnt) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if ({p1, p2, dir, pulse, st} !== {e.p1, e.p2, e.dir, e.pulse, e.st}) begin
        bad++;
        $display("FAIL sb_miss: got p1=%0d p2=%0d dir=%0b pulse=%0b st=%0d want p1=%0d p2=%0d dir=%0b pulse=%0b st=%0d",
                 p1, p2, dir, pulse, st, e.p1, e.p2, e.dir, e.pulse, e.st);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Drive one miss cycle and push its expected outcome.
  task automatic drive_miss(input logic l, input logic r, input logic t, input logic [2:0] cur);
    exp_t e;
    e.pulse = 1'b0;
    e.st = cur;
    if (cur == S_RALLY) begin
      e.st = S_POINT;
      if (l && !r) begin
        if (m_p2 != WIN) begin m_p2 = m_p2 + 1'b1; e.pulse = 1'b1; end
        m_dir = 1'b1;
      end
      if (r && !l) begin
        if (m_p1 != WIN) begin m_p1 = m_p1 + 1'b1; e.pulse = 1'b1; end
        m_dir = 1'b0;
      end
    end
    e.p1 = m_p1; e.p2 = m_p2; e.dir = m_dir;
    e.due = cyc_cnt + 1;
    sbq.push_back(e);
    miss_left = l; miss_right = r; tick = t;
    cyc();
    miss_left = 1'b0; miss_right = 1'b0; tick = 1'b0;
  endtask

  // From a fresh SERVE entry with serve_btn held: ticks spaced by idle cycles.
  task automatic do_serve(input string nm);
    serve_btn = 1'b1;
    for (int k = 0; k < STK; k++) begin
      total++;
      if (hold !== 1'b1 || st !== S_SERVE || (k > 0 && recenter !== 1'b0)) begin
        bad++;
        $display("FAIL %s_serve%0d: hold=%0b st=%0d rc=%0b want hold=1 st=1 rc=0", nm, k, hold, st, recenter);
      end
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    total++;
    if (hold !== 1'b0 || st !== S_RALLY) begin
      bad++;
      $display("FAIL %s_release: hold=%0b st=%0d want hold=0 st=2", nm, hold, st);
    end
    serve_btn = 1'b0;
  endtask

  // Run the POINT pause (already in POINT) and check where it ends up.
  task automatic finish_point(input string nm, input logic [2:0] nxt);
    for (int k = 0; k < PTK; k++) begin
      total++;
      if (st !== S_POINT || hold !== 1'b1) begin
        bad++;
        $display("FAIL %s_point%0d: st=%0d hold=%0b want st=3 hold=1", nm, k, st, hold);
      end
      tick = 1'b1; cyc(); tick = 1'b0;
    end
    cyc();
    total++;
    if (st !== nxt || recenter !== (nxt == S_SERVE)) begin
      bad++;
      $display("FAIL %s_exit: st=%0d rc=%0b want st=%0d rc=%0b", nm, st, recenter, nxt, nxt == S_SERVE);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    total++;
    if (st !== S_IDLE || hold !== 1'b1 || recenter !== 1'b0 || dir !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: st=%0d hold=%0b rc=%0b dir=%0b want 0 1 0 0", st, hold, recenter, dir);
    end
    total++;
    if (p1 !== 0 || p2 !== 0 || pulse !== 1'b0 || go !== 1'b0 || winner !== 1'b0) begin
      bad++;
      $display("FAIL reset_score: p1=%0d p2=%0d pulse=%0b go=%0b win=%0b want all 0", p1, p2, pulse, go, winner);
    end
    reset = 1'b0; cyc();
    total++;
    if (st !== S_IDLE) begin bad++; $display("FAIL idle_hold: st=%0d want 0", st); end
  endtask

  task automatic test_start();
    start = 1'b1; cyc(); start = 1'b0;
    total++;
    if (st !== S_SERVE || recenter !== 1'b1 || p1 !== 0 || p2 !== 0) begin
      bad++;
      $display("FAIL start: st=%0d rc=%0b p1=%0d p2=%0d want 1 1 0 0", st, recenter, p1, p2);
    end
    drive_miss(1'b1, 1'b0, 1'b0, S_SERVE);   // ignored outside RALLY
    do_serve("start");
  endtask

  task automatic test_point_right();
    drive_miss(1'b0, 1'b1, 1'b1, S_RALLY);   // tick on transition must not count
    total++;
    if (hold !== 1'b1) begin bad++; $display("FAIL pr_hold: hold=%0b want 1", hold); end
    cyc();
    total++;
    if (pulse !== 1'b0) begin bad++; $display("FAIL pr_pulse_once: pulse=%0b want 0", pulse); end
    finish_point("pr", S_SERVE);
    do_serve("pr");
  endtask

  task automatic test_both_miss();
    drive_miss(1'b1, 1'b1, 1'b0, S_RALLY);
    finish_point("both", S_SERVE);
    do_serve("both");
  endtask

  task automatic test_win();
    for (int i = 0; i < WIN; i++) begin
      drive_miss(1'b1, 1'b0, 1'b0, S_RALLY);
      finish_point("win", (i == WIN - 1) ? S_OVER : S_SERVE);
      if (i != WIN - 1) do_serve("win");
    end
    total++;
    if (go !== 1'b1 || winner !== 1'b1 || p2 !== WIN || hold !== 1'b1) begin
      bad++;
      $display("FAIL over: go=%0b win=%0b p2=%0d hold=%0b want 1 1 %0d 1", go, winner, p2, hold, WIN);
    end
    drive_miss(1'b0, 1'b1, 1'b0, S_OVER);    // frozen
    drive_miss(1'b1, 1'b0, 1'b0, S_OVER);
    start = 1'b1; cyc(); start = 1'b0;
    m_p1 = '0; m_p2 = '0; m_dir = 1'b0;
    total++;
    if (st !== S_SERVE || p1 !== 0 || p2 !== 0 || go !== 1'b0 || recenter !== 1'b1) begin
      bad++;
      $display("FAIL restart: st=%0d p1=%0d p2=%0d go=%0b rc=%0b want 1 0 0 0 1", st, p1, p2, go, recenter);
    end
  endtask

  task automatic test_serve_btn();
    serve_btn = 1'b0;
    for (int k = 0; k < STK; k++) begin tick = 1'b1; cyc(); tick = 1'b0; end
    total++;
    if (st !== S_SERVE) begin bad++; $display("FAIL sb_expiry: st=%0d want 1", st); end
    cyc();
`ifdef AUTO_SERVE_EN
    total++;
    if (st !== S_RALLY) begin bad++; $display("FAIL sb_auto: st=%0d want 2", st); end
`else
    for (int k = 0; k < 3; k++) begin
      total++;
      if (st !== S_SERVE) begin bad++; $display("FAIL sb_wait%0d: st=%0d want 1", k, st); end
      cyc();
    end
    serve_btn = 1'b1; cyc(); serve_btn = 1'b0;
    total++;
    if (st !== S_RALLY) begin bad++; $display("FAIL sb_press: st=%0d want 2", st); end
`endif
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (st !== S_RALLY) begin bad++; $display("FAIL start_in_rally%0d: st=%0d want 2", k, st); end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive_miss(1'b0, 1'b1, 1'b0, S_RALLY);
      finish_point("rm", S_SERVE);
      do_serve("rm");
    end
    total++;
    if (p1 !== 3) begin bad++; $display("FAIL rm_pre: p1=%0d want 3", p1); end
    reset = 1'b1; miss_right = 1'b1; cyc(); miss_right = 1'b0;
    total++;
    if (st !== S_IDLE || p1 !== 0 || p2 !== 0 || hold !== 1'b1 || recenter !== 1'b0 || pulse !== 1'b0) begin
      bad++;
      $display("FAIL rm_abort: st=%0d p1=%0d p2=%0d hold=%0b rc=%0b pulse=%0b want 0 0 0 1 0 0",
               st, p1, p2, hold, recenter, pulse);
    end
    reset = 1'b0; cyc();
    total++;
    if (st !== S_IDLE || pulse !== 1'b0) begin bad++; $display("FAIL rm_after: st=%0d pulse=%0b want 0 0", st, pulse); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_start();
    test_point_right();
    test_both_miss();
    test_win();
    test_serve_btn();
    test_reset_mid();
    cyc(); cyc();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_drain: left=%0d want 0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the Pong datapath; the only block that decides when the ball may move, when it is re-centred, which way it is served and when a score is committed.
- Consumes the frame-rate `tick`, the player start button and the left/right miss events from the bounce logic.
- Drives ball-hold/recentre/serve-direction into the ball datapath and per-player scores into the seven-segment decoders.

Parameters:
- WIN_SCORE, 9, score at which a match ends (1..15, must fit SCORE_W).
- SERVE_TICKS, 60, tick count of the serve countdown before the ball is released.
- POINT_TICKS, 90, tick count of the pause after a point before the next serve.
- SCORE_W, 4, width of each score counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- tick  in  1  single-cycle pulse, once per ball-update period.
- start  in  1  level, already debounced; starts or restarts a match.
- serve_btn  in  1  level; releases the ball from SERVE when AUTO_SERVE_EN is not defined.
- miss_left  in  1  single-cycle pulse; ball passed the left paddle, so P2 scores.
- miss_right  in  1  single-cycle pulse; ball passed the right paddle, so P1 scores.
- ball_hold  out  1  1 means the ball datapath must not move the ball.
- ball_recenter  out  1  one-cycle pulse; datapath loads the ball at (320,240).
- serve_dir  out  1  initial x-velocity bit: 0 = rightwards, 1 = leftwards.
- score_p1  out  SCORE_W  P1 score, binary.
- score_p2  out  SCORE_W  P2 score, binary.
- point_pulse  out  1  one-cycle pulse on each score increment, used for the sound effect.
- game_over  out  1  level while in state OVER.
- winner  out  1  0 = P1, 1 = P2; valid while game_over = 1.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; both scores = 0.
  - ball_hold = 1; ball_recenter = 0; serve_dir = 0; point_pulse = 0; game_over = 0; winner = 0.
  - Countdown = 0.
  - Reset asserted mid-match aborts the match with no pulses.
- States: IDLE, SERVE, RALLY, POINT, OVER.
- ball_hold = 0 only in RALLY.
- IDLE → SERVE on start = 1.
  - Scores cleared to 0; serve_dir = 0.
- Entry into SERVE (from any state):
  - ball_recenter pulses exactly once, in the first cycle after the transition.
  - Countdown loads SERVE_TICKS.
- SERVE:
  - Countdown decrements only on cycles with tick = 1.
  - At countdown = 0, with AUTO_SERVE_EN not defined: → RALLY in the first cycle where serve_btn = 1.
- RALLY:
  - miss_left alone: score_p2 += 1, point_pulse = 1, serve_dir = 1, → POINT.
  - miss_right alone: score_p1 += 1, point_pulse = 1, serve_dir = 0, → POINT.
  - Both misses in the same cycle: no score change, no point_pulse, serve_dir unchanged, → POINT.
  - Score and point_pulse are registered and appear 1 cycle after the miss pulse.
- Miss pulses outside RALLY are ignored.
- POINT:
  - Countdown loads POINT_TICKS on entry and decrements on tick.
  - At 0: if either score = WIN_SCORE, → OVER; otherwise → SERVE.
- OVER:
  - game_over = 1; winner = 1 if score_p2 = WIN_SCORE, else 0.
  - Scores are frozen.
  - start = 1 → SERVE with scores cleared.
- Arithmetic:
  - Scores never exceed WIN_SCORE; an increment at WIN_SCORE saturates.
  - Countdown width is clog2(max(SERVE_TICKS, POINT_TICKS)+1).
  - tick and a state transition in the same cycle: the transition wins; the countdown is reloaded, not decremented.
- start held high does not restart an ongoing match; it is only acted on in IDLE and OVER.

Optional Feature:
- Macro: AUTO_SERVE_EN.
  - Defined: SERVE → RALLY automatically when the countdown reaches 0; serve_btn is ignored.
  - Undefined: the countdown must reach 0 and serve_btn = 1 before release; serve_btn pressed before the countdown expires has no effect until then.

Decomposition:
- Package pong_pkg holds:
  - The state encoding (IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4).
  - The ball centre constants CX=320 and CY=240.
  - The serve_dir encoding constants.
- Sub-module tick_countdown: loadable down-counter with load, value and tick inputs and a zero flag; instantiated once and shared between SERVE and POINT.

Test Plan:
- Reset, then start = 1 for 1 cycle, AUTO_SERVE_EN defined, SERVE_TICKS=3 → ball_recenter pulses once; ball_hold = 1 for 3 ticks, then 0 (RALLY).
- In RALLY, miss_right pulse → next cycle score_p1 = 1, point_pulse = 1, serve_dir = 0, ball_hold = 1; after POINT_TICKS ticks, back in SERVE with ball_recenter pulsed.
- In RALLY, miss_left and miss_right in the same cycle → scores unchanged, no point_pulse, state POINT.
- WIN_SCORE=2, two miss_left events → after POINT expires, game_over = 1, winner = 1, score_p2 = 2; further misses ignored; start → scores 0, state SERVE.
- AUTO_SERVE_EN undefined: serve_btn held during the countdown → release only at the cycle the countdown reaches 0; serve_btn low at expiry → stays in SERVE until pressed.
- reset asserted in RALLY with score_p1 = 3 → next cycle state IDLE, scores 0, ball_hold = 1, no pulses.
